shift_sched: RTL and testbench
==============================

Name: shift_sched

Overview:
- Two-requester front end that sequences a multi-cycle 32-bit logical barrel/stepping shift for two clients.
- Arbitrates between the two requesters round-robin and captures one command per operation.
- Shifts the captured word by at most STEP bit positions per cycle until the requested amount is consumed, then holds the result on a valid/ready output.
- Sits between the shift-datapath clients and the shared shift resource, so that only one shift is ever in flight.

Parameters:
- WIDTH, 32: data width in bits.
- AMT_W, 6: width of the shift-amount field.
- STEP, 4: maximum bit positions shifted per cycle. Must be ≥1 and ≤WIDTH.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- clr  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a command.
- req0_ready  out  1  requester 0 command accepted this cycle when also valid.
- req0_dir  in  1  0 = shift left, 1 = shift right (logical, zero fill).
- req0_amt  in  AMT_W  shift amount.
- req0_data  in  WIDTH  operand.
- req1_valid, req1_ready, req1_dir, req1_amt, req1_data: same as the req0 signals, for requester 1.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes result.
- res_data  out  WIDTH  shifted result.
- res_id  out  1  index of the requester that owns res_data.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset:
  - clr sampled high → state IDLE, rr_ptr = 0 (req0 preferred), res_valid = 0, res_data = 0, res_id = 0, remaining count = 0.
  - Both reqX_ready are forced 0 in any cycle where clr is high.
  - clr overrides all other activity, including mid-SHIFT or mid-DONE: the in-flight operation is discarded and no res_valid is ever issued for it.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - Winner = the only valid requester. If both are valid, winner = rr_ptr.
  - req_ready is high combinationally only for the winner; the loser's ready stays 0.
  - Accept = winner valid & ready.
  - On accept: capture data, dir, id. Set rem = min(amt, WIDTH). Set rr_ptr = the other requester.
  - Next state: SHIFT if rem ≠ 0, else DONE.
  - If nothing is valid: stay in IDLE, rr_ptr unchanged.
- SHIFT:
  - Each cycle shift by s = min(STEP, rem) in the captured direction, zero fill; rem -= s.
  - Go to DONE when the post-step rem is 0.
  - reqX_ready = 0 throughout.
- DONE:
  - res_valid = 1; res_data and res_id are stable.
  - Leave to IDLE on res_valid & res_ready.
  - reqX_ready = 0, so there is no same-cycle accept. The earliest next accept is the cycle after the handoff.
- Latency:
  - With the command accepted in cycle c and n = min(amt, WIDTH), res_valid first high in cycle c + 1 + ceil(n/STEP).
  - amt = 0 → result equals the operand at c+1.
  - amt ≥ WIDTH → result = 0, with latency computed using n = WIDTH.
- Arithmetic and widths:
  - rem is wide enough to hold WIDTH.
  - The shift step never exceeds rem.
  - res_data changes only in SHIFT and on accept; it is held through DONE.
- Round-robin rule: rr_ptr updates only on accept, never on a cycle with no grant.

Test Plan:
- Reset: hold clr high for 2 cycles with both valids high → req0_ready = req1_ready = 0, res_valid = 0, res_data = 0, busy = 0. Release clr → req0 granted first.
- Left shift: req0 with data 0x7105c1a6, amt 27, dir 0, STEP = 4, accepted in cycle c → busy from c+1, res_valid first at c+8, res_data = 0x30000000, res_id = 0.
- Right shift: req1 with data 0x7105c1a6, amt 27, dir 1, with req0 idle → res_data = 0x0000000E at c+8, res_id = 1.
- Edge amounts:
  - amt 0 → res_data = 0x7105c1a6 at c+1.
  - amt 40 → res_data = 0x00000000 at c+9.
  - amt 4 → res_data = 0x105c1a60 at c+2.
- Arbitration: both requesters valid continuously with res_ready = 1 and amt 0 → grant order 0, 1, 0, 1. Each accept is separated by exactly 2 cycles (DONE handoff, then IDLE accept). res_id alternates.
- Backpressure/abort:
  - Hold res_ready low for 5 cycles in DONE → res_valid, res_data, res_id stable and both readies 0.
  - Separately, assert clr during SHIFT → IDLE on the next cycle, no res_valid, res_data = 0.

Source files
------------

// File: rtl/shift_sched.sv
// Two-requester round-robin front end for a multi-cycle stepping logical shifter.
// One command in flight at a time; result held on a valid/ready output until taken.
module shift_sched #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 6,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_dir,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_dir,
  input  logic [AMT_W-1:0] req1_amt,
  input  logic [WIDTH-1:0] req1_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for a command; the winning requester sees ready
  // SHIFT | stepping the captured word by up to STEP bits per cycle
  // DONE  | result presented on res_*; waits for res_ready

  localparam int RW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic             rr_ptr;
  logic             dir_q;
  logic [RW-1:0]    rem;
  logic             winner;
  logic             grant0;
  logic             grant1;
  logic [AMT_W-1:0] amt_sel;
  logic [31:0]      amt_ext;
  logic [RW-1:0]    n_sel;
  logic [RW-1:0]    step_n;

  always_comb begin
    winner  = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    amt_sel = winner ? req1_amt : req0_amt;
    amt_ext = 32'(amt_sel);
    // Amounts at or beyond WIDTH saturate so the result drains to zero.
    if (amt_ext > 32'(WIDTH)) n_sel = RW'(WIDTH);
    else                      n_sel = RW'(amt_sel);
    step_n  = (rem < RW'(STEP)) ? rem : RW'(STEP);
  end

  assign grant0     = (state == IDLE) && !clr && req0_valid && !winner;
  assign grant1     = (state == IDLE) && !clr && req1_valid &&  winner;
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign res_valid  = (state == DONE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      dir_q    <= 1'b0;
      rem      <= '0;
      res_data <= '0;
      res_id   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            res_data <= winner ? req1_data : req0_data;
            dir_q    <= winner ? req1_dir : req0_dir;
            res_id   <= winner;
            rem      <= n_sel;
            rr_ptr   <= ~winner;
            state    <= (n_sel != '0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          res_data <= dir_q ? (res_data >> step_n) : (res_data << step_n);
          rem      <= rem - step_n;
          if (rem == step_n) state <= DONE;
        end
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sched.sv
// Self-checking bench for shift_sched: directed edge cases, arbitration, abort,
// and randomized commands checked against an arithmetic reference model.
module tb_shift_sched;

  logic        clk = 1'b0;
  logic        clr;
  logic        req0_valid, req0_ready, req0_dir;
  logic [5:0]  req0_amt;
  logic [31:0] req0_data;
  logic        req1_valid, req1_ready, req1_dir;
  logic [5:0]  req1_amt;
  logic [31:0] req1_data;
  logic        res_valid, res_ready, res_id, busy;
  logic [31:0] res_data;

  int checks = 0;
  int errors = 0;
  bit exp_rr = 1'b0;

  shift_sched dut (
    .clk(clk), .clr(clr),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_dir(req0_dir),
    .req0_amt(req0_amt), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_dir(req1_dir),
    .req1_amt(req1_amt), .req1_data(req1_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_shift(input logic [31:0] d, input bit dir, input int amt);
    if (amt >= 32) return 32'h0;
    return dir ? (d >> amt) : (d << amt);
  endfunction

  function automatic int model_latency(input int amt);
    int n;
    n = (amt > 32) ? 32 : amt;
    return 1 + (n + 3) / 4;
  endfunction

  // Issues one command (one or both requesters valid), follows it to the
  // result, optionally stalls the consumer, then hands the result off.
  task automatic run_op(input bit v0, input bit v1,
                        input bit d0, input bit d1,
                        input int a0, input int a1,
                        input logic [31:0] x0, input logic [31:0] x1,
                        input int hold);
    bit          w;
    bit          got;
    int          k;
    int          amt;
    logic [31:0] exp_d;
    req0_valid = v0; req0_dir = d0; req0_amt = 6'(a0); req0_data = x0;
    req1_valid = v1; req1_dir = d1; req1_amt = 6'(a1); req1_data = x1;
    w = (v0 && v1) ? exp_rr : v1;
    #1;
    check("ready0_grant", req0_ready, 32'(w == 1'b0));
    check("ready1_grant", req1_ready, 32'(w == 1'b1));
    @(posedge clk);
    #1 req0_valid = 1'b0; req1_valid = 1'b0;
    exp_rr = !w;
    amt   = w ? a1 : a0;
    exp_d = w ? model_shift(x1, d1, a1) : model_shift(x0, d0, a0);
    k = 0; got = 1'b0;
    while (k < 40 && !got) begin
      @(negedge clk);
      k++;
      if (k == 1) check("busy_after_accept", busy, 1);
      if (res_valid) got = 1'b1;
    end
    check("res_valid_seen", 32'(got), 1);
    check("latency", k, model_latency(amt));
    check("res_data", res_data, exp_d);
    check("res_id", res_id, 32'(w));
    for (int h = 0; h < hold; h++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      @(negedge clk);
      check("hold_valid", res_valid, 1);
      check("hold_data", res_data, exp_d);
      check("hold_id", res_id, 32'(w));
      check("hold_readies", {req0_ready, req1_ready}, 0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int          grants;
    int          last_cyc;
    int          cyc;
    bit          last_g;
    bit          seen;
    logic [31:0] dat [2];

    clr = 1'b1; res_ready = 1'b0;
    req0_valid = 1'b1; req0_dir = 1'b0; req0_amt = 6'd0; req0_data = 32'h1234_5678;
    req1_valid = 1'b1; req1_dir = 1'b0; req1_amt = 6'd0; req1_data = 32'h9abc_def0;
    repeat (2) begin
      @(negedge clk);
      check("rst_readies", {req0_ready, req1_ready}, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_data", res_data, 0);
      check("rst_busy", busy, 0);
    end
    clr = 1'b0;
    #1;
    check("rst_release_r0", req0_ready, 1);
    check("rst_release_r1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);

    // Directed cases from the datasheet values.
    run_op(1, 0, 0, 0, 27, 0, 32'h7105c1a6, 32'h0, 0);
    run_op(0, 1, 0, 1, 0, 27, 32'h0, 32'h7105c1a6, 0);
    run_op(1, 0, 0, 0, 0, 0, 32'h7105c1a6, 32'h0, 0);
    run_op(0, 1, 0, 0, 0, 40, 32'h0, 32'h7105c1a6, 0);
    run_op(1, 0, 0, 0, 4, 0, 32'h7105c1a6, 32'h0, 5);

    // Arbitration: both valid, amt 0, consumer always ready.
    dat[0] = 32'hAAAA_0001; dat[1] = 32'h5555_0002;
    req0_valid = 1'b1; req0_dir = 1'b0; req0_amt = 6'd0; req0_data = dat[0];
    req1_valid = 1'b1; req1_dir = 1'b1; req1_amt = 6'd0; req1_data = dat[1];
    res_ready = 1'b1;
    grants = 0; last_cyc = -1; last_g = 1'b0; cyc = 0;
    while (grants < 4 && cyc < 20) begin
      #1;
      if (req0_ready || req1_ready) begin
        check("arb_one_grant", {req0_ready, req1_ready} == 2'b11, 0);
        check("arb_order", 32'(req1_ready), 32'(exp_rr));
        if (last_cyc >= 0) check("arb_spacing", cyc - last_cyc, 2);
        last_g = req1_ready; last_cyc = cyc; exp_rr = !req1_ready;
        grants++;
      end
      if (res_valid) begin
        check("arb_res_id", res_id, 32'(last_g));
        check("arb_res_data", res_data, dat[last_g]);
      end
      @(negedge clk);
      cyc++;
    end
    check("arb_grant_count", grants, 4);
    @(posedge clk);
    #1 req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check("arb_last_res_id", res_id, 32'(last_g));
    repeat (2) @(negedge clk);
    res_ready = 1'b0;

    // Abort mid-SHIFT.
    req0_valid = 1'b1; req0_dir = 1'b0; req0_amt = 6'd27; req0_data = 32'h7105c1a6;
    req1_valid = 1'b0;
    @(posedge clk);
    #1 req0_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_pre_busy", busy, 1);
    check("abort_pre_valid", res_valid, 0);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    exp_rr = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_valid", res_valid, 0);
    check("abort_data", res_data, 0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    check("abort_no_result", 32'(seen), 0);
    run_op(1, 1, 1, 0, 8, 8, 32'hF000_0000, 32'h0000_000F, 0);

    // Randomized commands.
    for (int i = 0; i < 24; i++) begin
      int sel;
      sel = $urandom_range(0, 2);
      run_op(sel != 1, sel != 0,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 63), $urandom_range(0, 63),
             $urandom, $urandom, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
